vai_c1tx_arbiter: RTL and testbench
===================================

# vai_c1tx_arbiter

Round-robin scheduler that shares the single CCI-P c1 Tx (write request) channel among `NUM_SUB_AFUS` sub-AFUs behind the VAI mux. Each requester gets a private skid FIFO and an almost-full flag. The block grants at most one request per cycle, honouring the upstream c1 almost-full signal and per-sub-AFU reset from the VAI manager. Its output feeds the manager's c1 Tx path in place of a single pre-muxed stream.

## Interface
- `NUM_SUB_AFUS`, 8: number of requesters; power of two, 2..64.
- `DATA_WIDTH`, `$bits(t_if_ccip_c1_Tx)`: payload width per request.
- `DEPTH`, 8: per-requester FIFO entries; power of two.
- `ALM_SLACK`, 4: free entries remaining when `req_almfull` asserts; must be less than `DEPTH`.

- `Clk`  in  1  sole clock (pClk domain).
- `Resetb`  in  1  asynchronous, active-low reset.
- `req_valid`  in  NUM_SUB_AFUS  per-requester write strobe.
- `req_data`  in  NUM_SUB_AFUS x DATA_WIDTH  per-requester payload.
- `req_almfull`  out  NUM_SUB_AFUS  per-requester backpressure.
- `sub_afu_reset`  in  NUM_SUB_AFUS  synchronous per-requester flush, from the manager's reset register.
- `up_almfull`  in  1  upstream `c1TxAlmFull`.
- `out_valid`  out  1  granted request valid.
- `out_data`  out  DATA_WIDTH  granted payload.
- `out_vmid`  out  clog2(NUM_SUB_AFUS)  index of the granted requester.
- `overflow`  out  NUM_SUB_AFUS  sticky: a write was dropped while the FIFO was full.

## Operation
- **FIFO write**
  - `req_valid[i]` at a rising edge pushes `req_data[i]` into FIFO i when FIFO i is not full and `sub_afu_reset[i]` is low.
  - A write when FIFO i is full is dropped and sets `overflow[i]`.
- **Occupancy**
  - Each FIFO has a count of width clog2(DEPTH)+1.
  - Read and write pointers wrap modulo DEPTH.
  - A simultaneous push and pop leaves the count unchanged.
- **Backpressure:** `req_almfull[i]` = count_i >= DEPTH-ALM_SLACK (registered).
- **Eligibility:** requester i is eligible when FIFO i is non-empty and `sub_afu_reset[i]` is low.
- **Grant**
  - No grant in a cycle where `up_almfull` is high.
  - Otherwise the first eligible requester at or after `rr_ptr` (wrapping modulo NUM_SUB_AFUS) is granted, and its head entry is popped.
- **Pointer update:** on grant to k, `rr_ptr` <= (k+1) mod NUM_SUB_AFUS. With no grant, `rr_ptr` holds.
- **Output register:** `out_valid`, `out_data` and `out_vmid` are registered from the grant. With no grant, `out_valid` is 0 and `out_data`/`out_vmid` hold their last values.
- **Per-requester flush**
  - While `sub_afu_reset[i]` is high: FIFO i is emptied (pointers and count cleared), incoming writes are ignored, `overflow[i]` is cleared, and `req_almfull[i]` reads 0.
  - Other requesters are unaffected.
  - An entry of requester i already in the output register is still emitted.
- **Global reset:** `Resetb` low clears all FIFOs, `rr_ptr`=0, `out_valid`=0, `out_data`=0, `out_vmid`=0, `overflow`=0, `req_almfull`=0. This takes effect asynchronously, including mid-burst.

## Timing
- **Latency:** `req_valid[i]` sampled at edge E0, into an empty FIFO i, with no competition and `up_almfull` low → `out_valid`=1 with that data after E1. That is one cycle after the request cycle.
- **Throughput:** one grant per cycle sustained across requesters. A single requester with a full FIFO drains at 1/cycle.
- **Upstream stall:** `up_almfull` is sampled in the grant cycle. Pop and `out_valid` are suppressed the same cycle, with no additional pipeline stage.
- **Almost-full lag:** `req_almfull` lags the count by one cycle. `ALM_SLACK` covers this lag plus the requester pipeline.
- **Reset release:** the first grant is possible one cycle after the first write following `Resetb` deassertion.

## Test plan
- **Single request:** after reset, requester 3 writes payload 0xA5 once with `up_almfull`=0 → next cycle `out_valid`=1, `out_data`=0xA5, `out_vmid`=3; then `out_valid`=0.
- **Round-robin fairness:** all 8 requesters each hold 4 entries, with `rr_ptr`=0 → `out_vmid` sequence 0,1,...,7,0,1,... for 32 consecutive cycles with `out_valid` continuously 1.
- **Upstream stall:** hold `up_almfull`=1 for 5 cycles while requesters 0 and 5 are non-empty → `out_valid`=0 for those 5 cycles and no entry is lost. After release, grants go 0 then 5, preserving per-FIFO order.
- **Fill and overflow:** requester 2 writes 10 entries back-to-back with `up_almfull`=1, `DEPTH`=8 → `req_almfull[2]`=1 from the cycle after the 4th write; `overflow[2]`=1 after the 9th write; entries 9 and 10 are dropped. After release exactly 8 entries emerge in order.
- **Flush:** requester 4 holds 6 entries, then `sub_afu_reset[4]` is pulsed for 1 cycle while requester 1 holds 3 → no further `out_vmid`=4 beyond any entry already registered; requester 1's 3 entries all emerge; `overflow[4]`=0.
- **Async reset mid-burst:** drive `Resetb` low between edges during a continuous grant stream → `out_valid`=0 immediately. After release, a new single write yields `out_vmid` matching that requester, and `rr_ptr` restarts at 0.

Source files
------------

// File: rtl/vai_c1tx_arbiter.sv
// Round-robin c1 Tx scheduler: per-requester skid FIFOs, one grant per cycle into a registered output.
// Latency 1 cycle from write to out_valid_o; up_almfull_i stalls grants the same cycle, FIFOs absorb and raise req_almfull_o.

module vai_c1tx_fifo #(
  parameter int W     = 64,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = AW + 1
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic [CW-1:0] count_o
);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Callers only push when not full and not flushing, and only pop when non-empty.
  always_ff @(posedge clk_i) begin
    if (push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_i) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop_i)  rd_ptr_d = rd_ptr_q + AW'(1);
      count_d = count_q + CW'(push_i) - CW'(pop_i);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
endmodule

module vai_c1tx_arbiter #(
  parameter int NUM_SUB_AFUS = 8,
  parameter int DATA_WIDTH   = 64,
  parameter int DEPTH        = 8,
  parameter int ALM_SLACK    = 4,
  localparam int VW          = $clog2(NUM_SUB_AFUS),
  localparam int CW          = $clog2(DEPTH) + 1
) (
  input  logic                                    clk_i,
  input  logic                                    rst_n_i,
  input  logic [NUM_SUB_AFUS-1:0]                 req_valid_i,
  input  logic [NUM_SUB_AFUS-1:0][DATA_WIDTH-1:0] req_data_i,
  output logic [NUM_SUB_AFUS-1:0]                 req_almfull_o,
  input  logic [NUM_SUB_AFUS-1:0]                 sub_afu_reset_i,
  input  logic                                    up_almfull_i,
  output logic                                    out_valid_o,
  output logic [DATA_WIDTH-1:0]                   out_data_o,
  output logic [VW-1:0]                           out_vmid_o,
  output logic [NUM_SUB_AFUS-1:0]                 overflow_o
);
  localparam logic [CW-1:0] ALM_TH = CW'(DEPTH - ALM_SLACK);

  logic [NUM_SUB_AFUS-1:0][CW-1:0]         count;
  logic [NUM_SUB_AFUS-1:0][DATA_WIDTH-1:0] head;
  logic [NUM_SUB_AFUS-1:0]                 full, push, pop, elig;
  logic [NUM_SUB_AFUS-1:0]                 ovf_q, ovf_d, alm_q, alm_d;
  logic [VW-1:0]                           rr_ptr_q, gnt_idx, scan_idx;
  logic                                    gnt_vld;
  logic                                    out_valid_q;
  logic [DATA_WIDTH-1:0]                   out_data_q;
  logic [VW-1:0]                           out_vmid_q;

  for (genvar g = 0; g < NUM_SUB_AFUS; g++) begin : g_req
    assign full[g] = (count[g] == CW'(DEPTH));
    assign push[g] = req_valid_i[g] & ~full[g] & ~sub_afu_reset_i[g];
    assign elig[g] = (count[g] != '0) & ~sub_afu_reset_i[g];

    vai_c1tx_fifo #(.W(DATA_WIDTH), .DEPTH(DEPTH)) u_fifo (
      .clk_i   (clk_i),
      .rst_n_i (rst_n_i),
      .flush_i (sub_afu_reset_i[g]),
      .push_i  (push[g]),
      .pop_i   (pop[g]),
      .wdata_i (req_data_i[g]),
      .rdata_o (head[g]),
      .count_o (count[g])
    );
  end

  // Scan starts at rr_ptr_q and wraps naturally since NUM_SUB_AFUS is a power of two.
  always_comb begin
    gnt_vld  = 1'b0;
    gnt_idx  = '0;
    scan_idx = '0;
    if (!up_almfull_i) begin
      for (int j = 0; j < NUM_SUB_AFUS; j++) begin
        scan_idx = rr_ptr_q + VW'(j);
        if (!gnt_vld && elig[scan_idx]) begin
          gnt_vld = 1'b1;
          gnt_idx = scan_idx;
        end
      end
    end
  end

  always_comb begin
    pop = '0;
    if (gnt_vld) pop[gnt_idx] = 1'b1;
  end

  always_comb begin
    ovf_d = (ovf_q | (req_valid_i & full)) & ~sub_afu_reset_i;
    alm_d = '0;
    for (int i = 0; i < NUM_SUB_AFUS; i++) begin
      alm_d[i] = ~sub_afu_reset_i[i] & (count[i] >= ALM_TH);
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_vmid_q  <= '0;
      ovf_q       <= '0;
      alm_q       <= '0;
    end else begin
      out_valid_q <= gnt_vld;
      ovf_q       <= ovf_d;
      alm_q       <= alm_d;
      if (gnt_vld) begin
        rr_ptr_q   <= gnt_idx + VW'(1);
        out_data_q <= head[gnt_idx];
        out_vmid_q <= gnt_idx;
      end
    end
  end

  // A flushing requester must read not-almost-full during the flush cycle itself.
  assign req_almfull_o = alm_q & ~sub_afu_reset_i;
  assign out_valid_o   = out_valid_q;
  assign out_data_o    = out_data_q;
  assign out_vmid_o    = out_vmid_q;
  assign overflow_o    = ovf_q;
endmodule

// File: tb/tb_vai_c1tx_arbiter.sv
// Bench for vai_c1tx_arbiter: queue-based reference model compared every cycle, plus directed literal checks.
module tb_vai_c1tx_arbiter;
  localparam int N     = 8;
  localparam int DW    = 16;
  localparam int DEPTH = 8;
  localparam int SLACK = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n = 1'b0;
  logic [N-1:0]         req_valid = '0;
  logic [N-1:0][DW-1:0] req_data = '0;
  logic [N-1:0]         sres = '0;
  logic                 up = 1'b0;
  logic [N-1:0]         req_almfull;
  logic                 out_valid;
  logic [DW-1:0]        out_data;
  logic [2:0]           out_vmid;
  logic [N-1:0]         overflow;

  vai_c1tx_arbiter #(
    .NUM_SUB_AFUS(N), .DATA_WIDTH(DW), .DEPTH(DEPTH), .ALM_SLACK(SLACK)
  ) dut (
    .clk_i           (clk),
    .rst_n_i         (rst_n),
    .req_valid_i     (req_valid),
    .req_data_i      (req_data),
    .req_almfull_o   (req_almfull),
    .sub_afu_reset_i (sres),
    .up_almfull_i    (up),
    .out_valid_o     (out_valid),
    .out_data_o      (out_data),
    .out_vmid_o      (out_vmid),
    .overflow_o      (overflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: one queue per requester, outputs updated at each clock edge.
  logic [DW-1:0] mq [N][$];
  int            m_sz [N];
  int            m_g;
  int            m_rr = 0;
  logic          m_ov = 1'b0;
  logic [DW-1:0] m_od = '0;
  int            m_vm = 0;
  logic [N-1:0]  m_ovf = '0;
  logic [N-1:0]  m_alm = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) mq[i].delete();
      m_rr = 0; m_ov = 1'b0; m_od = '0; m_vm = 0; m_ovf = '0; m_alm = '0;
    end else begin
      for (int i = 0; i < N; i++) m_sz[i] = mq[i].size();
      m_g = -1;
      if (!up) begin
        for (int j = 0; j < N; j++) begin
          if (m_g < 0 && m_sz[(m_rr + j) % N] > 0 && !sres[(m_rr + j) % N]) m_g = (m_rr + j) % N;
        end
      end
      for (int i = 0; i < N; i++) m_alm[i] = !sres[i] && (m_sz[i] >= DEPTH - SLACK);
      m_ov = (m_g >= 0);
      if (m_g >= 0) begin
        m_od = mq[m_g].pop_front();
        m_vm = m_g;
        m_rr = (m_g + 1) % N;
      end
      for (int i = 0; i < N; i++) begin
        if (sres[i]) begin
          mq[i].delete();
          m_ovf[i] = 1'b0;
        end else if (req_valid[i]) begin
          if (m_sz[i] >= DEPTH) m_ovf[i] = 1'b1;
          else mq[i].push_back(req_data[i]);
        end
      end
    end
  end

  always @(negedge clk) begin
    check("model_out_valid", out_valid, m_ov);
    check("model_out_vmid", out_vmid, m_vm);
    check("model_out_data", out_data, m_od);
    check("model_overflow", overflow, m_ovf);
    check("model_req_almfull", req_almfull, m_alm & ~sres);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic global_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  int exp_vm[4] = '{0, 5, 0, 5};
  logic [DW-1:0] exp_d[4] = '{16'h100, 16'h150, 16'h101, 16'h151};

  initial begin
    tick();
    tick();
    check("reset_out_valid", out_valid, 0);
    check("reset_out_vmid", out_vmid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_overflow", overflow, 0);
    check("reset_almfull", req_almfull, 0);
    rst_n = 1'b1;
    tick();

    // Single request from requester 3
    req_valid[3] = 1'b1; req_data[3] = 16'h00A5;
    tick();
    req_valid = '0;
    tick();
    check("single_valid", out_valid, 1);
    check("single_data", out_data, 16'h00A5);
    check("single_vmid", out_vmid, 3);
    tick();
    check("single_valid_drop", out_valid, 0);

    // Round-robin over 8 requesters x 4 entries
    global_reset();
    up = 1'b1;
    for (int w = 0; w < 4; w++) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i] = 1'b1;
        req_data[i]  = DW'(i * 16 + w);
      end
      tick();
    end
    req_valid = '0;
    up = 1'b0;
    for (int n = 0; n < 32; n++) begin
      tick();
      check("rr_valid", out_valid, 1);
      check("rr_vmid", out_vmid, n % 8);
      check("rr_data", out_data, (n % 8) * 16 + n / 8);
    end
    tick();
    check("rr_idle", out_valid, 0);

    // Upstream stall with requesters 0 and 5 pending
    up = 1'b1;
    for (int w = 0; w < 2; w++) begin
      req_valid[0] = 1'b1; req_data[0] = DW'(16'h100 + w);
      req_valid[5] = 1'b1; req_data[5] = DW'(16'h150 + w);
      tick();
    end
    req_valid = '0;
    for (int s = 0; s < 5; s++) begin
      tick();
      check("stall_valid", out_valid, 0);
    end
    up = 1'b0;
    for (int n = 0; n < 4; n++) begin
      tick();
      check("stall_rel_valid", out_valid, 1);
      check("stall_rel_vmid", out_vmid, exp_vm[n]);
      check("stall_rel_data", out_data, exp_d[n]);
    end
    tick();
    check("stall_idle", out_valid, 0);

    // Fill requester 2 past capacity while stalled
    up = 1'b1;
    for (int n = 0; n < 10; n++) begin
      req_valid[2] = 1'b1; req_data[2] = DW'(16'h200 + n);
      tick();
      if (n == 2) check("fill_almfull_low", req_almfull[2], 0);
      if (n == 4) check("fill_almfull_high", req_almfull[2], 1);
      if (n == 7) check("fill_ovf_low", overflow[2], 0);
      if (n == 8) check("fill_ovf_high", overflow[2], 1);
    end
    req_valid = '0;
    up = 1'b0;
    for (int n = 0; n < 8; n++) begin
      tick();
      check("fill_drain_valid", out_valid, 1);
      check("fill_drain_vmid", out_vmid, 2);
      check("fill_drain_data", out_data, 16'h200 + n);
    end
    tick();
    check("fill_drain_idle", out_valid, 0);
    check("fill_ovf_sticky", overflow[2], 1);

    // Flush requester 4 (and 2) while requester 1 drains
    up = 1'b1;
    for (int n = 0; n < 6; n++) begin
      req_valid[4] = 1'b1; req_data[4] = DW'(16'h400 + n);
      req_valid[1] = (n < 3); req_data[1] = DW'(16'h310 + n);
      tick();
    end
    req_valid = '0;
    up = 1'b0;
    tick();
    check("flush_first_vmid", out_vmid, 4);
    check("flush_first_data", out_data, 16'h400);
    sres[4] = 1'b1; sres[2] = 1'b1;
    tick();
    sres = '0;
    check("flush_r1_vmid0", out_vmid, 1);
    check("flush_r1_data0", out_data, 16'h310);
    tick();
    check("flush_r1_data1", out_data, 16'h311);
    tick();
    check("flush_r1_vmid2", out_vmid, 1);
    check("flush_r1_data2", out_data, 16'h312);
    tick();
    check("flush_idle", out_valid, 0);
    check("flush_ovf_clear", overflow, 0);

    // Async reset in the middle of a grant stream
    up = 1'b1;
    for (int w = 0; w < 2; w++) begin
      for (int i = 0; i < N; i++) begin
        req_valid[i] = 1'b1;
        req_data[i]  = DW'(16'h500 + i * 16 + w);
      end
      tick();
    end
    req_valid = '0;
    up = 1'b0;
    for (int n = 0; n < 3; n++) begin
      tick();
      check("burst_valid", out_valid, 1);
      check("burst_vmid", out_vmid, 2 + n);
    end
    #3;
    rst_n = 1'b0;
    #1;
    check("async_valid", out_valid, 0);
    check("async_vmid", out_vmid, 0);
    check("async_data", out_data, 0);
    tick();
    tick();
    #2;
    rst_n = 1'b1;
    tick();
    req_valid[2] = 1'b1; req_data[2] = 16'h0602;
    req_valid[6] = 1'b1; req_data[6] = 16'h0606;
    tick();
    req_valid = '0;
    tick();
    check("post_rst_valid", out_valid, 1);
    check("post_rst_vmid0", out_vmid, 2);
    check("post_rst_data0", out_data, 16'h0602);
    tick();
    check("post_rst_vmid1", out_vmid, 6);
    check("post_rst_data1", out_data, 16'h0606);
    tick();
    check("post_rst_idle", out_valid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
